// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings, width and EX/MEM entry layout for the pipeline
package pipe_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_XOR   = 4'd2,
        ALU_ANDN  = 4'd3,
        ALU_ROL   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_ROR   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_PASSB = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        SET_SEQ = 2'd0,
        SET_SLT = 2'd1,
        SET_SLE = 2'd2,
        SET_SCO = 2'd3
    } set_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQZ = 3'd1,
        BR_BNEZ = 3'd2,
        BR_BLTZ = 3'd3,
        BR_BGEZ = 3'd4,
        BR_JREG = 3'd5
    } br_op_e;

    typedef struct packed {
        logic [WIDTH-1:0] alu_out;
        logic [WIDTH-1:0] set_val;
        logic [WIDTH-1:0] reg1_data;
        logic [WIDTH-1:0] reg2_data;
        logic [WIDTH-1:0] next_pc;
        logic [WIDTH-1:0] instr;
        logic             mem_wrt;
        logic             mem_en;
        logic             reg_wrt;
        logic             halt;
        logic             valid;
        logic [2:0]       reg_wrt_src;
        logic [2:0]       write_reg;
        logic             branch_taken;
        logic [WIDTH-1:0] branch_target;
        logic             err;
    } exmem_t;

    // An empty slot: every control bit low, data don't-care (zeroed here).
    localparam exmem_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/alu16.sv
// rtl/alu16.sv - combinational ALU with set-compare and illegal-opcode flag
module alu16
    import pipe_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    input  logic [1:0]       set_op,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] set_val,
    output logic             illegal
);

    logic [3:0]         amt;
    logic [WIDTH:0]     sum17;
    logic [2*WIDTH-1:0] rol_w;
    logic [2*WIDTH-1:0] ror_w;

    assign amt   = b[3:0];
    assign sum17 = {1'b0, a} + {1'b0, b};
    // Rotates shift a doubled copy so the wrapped bits fall into the kept half.
    assign rol_w = {a, a} << amt;
    assign ror_w = {a, a} >> amt;

    // Arithmetic/logic result selection; unused codes flag illegal.
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_op)
            ALU_ADD:   result = sum17[WIDTH-1:0];
            ALU_SUB:   result = b - a;
            ALU_XOR:   result = a ^ b;
            ALU_ANDN:  result = a & ~b;
            ALU_ROL:   result = rol_w[2*WIDTH-1:WIDTH];
            ALU_SLL:   result = a << amt;
            ALU_ROR:   result = ror_w[WIDTH-1:0];
            ALU_SRL:   result = a >> amt;
            ALU_PASSB: result = b;
            default:   illegal = 1'b1;
        endcase
    end

    // Set-compare produces a 0/1 value in the low bit.
    always_comb begin
        set_val = '0;
        case (set_op)
            SET_SEQ: set_val[0] = (a == b);
            SET_SLT: set_val[0] = ($signed(a) < $signed(b));
            SET_SLE: set_val[0] = ($signed(a) <= $signed(b));
            default: set_val[0] = sum17[WIDTH];
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage with EX/MEM register; EXECUTE_STAGE_FWD_EN adds operand forwarding
module execute_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = pipe_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] nextPcIn,
    input  logic [WIDTH-1:0] reg1Data,
    input  logic [WIDTH-1:0] reg2Data,
    input  logic [WIDTH-1:0] immVal,
    input  logic             aluSrc,
    input  logic [3:0]       aluOp,
    input  logic [1:0]       setOp,
    input  logic [2:0]       brOp,
    input  logic             memWrtIn,
    input  logic             memEnIn,
    input  logic             regWrtIn,
    input  logic             haltIn,
    input  logic [2:0]       regWrtSrcIn,
    input  logic [2:0]       writeRegIn,
    input  logic             stall,
    output logic [WIDTH-1:0] aluOut,
    output logic [WIDTH-1:0] setVal,
    output logic [WIDTH-1:0] reg1DataOut,
    output logic [WIDTH-1:0] reg2DataOut,
    output logic [WIDTH-1:0] nextPc,
    output logic [WIDTH-1:0] instrOut,
    output logic             memWrt,
    output logic             memEn,
    output logic             regWrt,
    output logic             halt,
    output logic             valid,
    output logic [2:0]       regWrtSrc,
    output logic [2:0]       writeReg,
    output logic             branchTaken,
    output logic [WIDTH-1:0] branchTarget,
    output logic             err
`ifdef EXECUTE_STAGE_FWD_EN
    ,
    input  logic             memFwdWrt,
    input  logic [2:0]       memFwdReg,
    input  logic [WIDTH-1:0] memFwdData,
    input  logic             wbFwdWrt,
    input  logic [2:0]       wbFwdReg,
    input  logic [WIDTH-1:0] wbFwdData,
    input  logic [2:0]       srcRegA,
    input  logic [2:0]       srcRegB
`endif
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] reg2_fwd;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] set_result;
    logic             alu_illegal;
    logic             br_cond;
    logic             br_illegal;
    logic [WIDTH-1:0] br_target;
    exmem_t           d;
    exmem_t           q;

`ifdef EXECUTE_STAGE_FWD_EN
    // The younger EX/MEM result wins over the older MEM/WB result.
    always_comb begin
        op_a = reg1Data;
        if (memFwdWrt && (memFwdReg == srcRegA))
            op_a = memFwdData;
        else if (wbFwdWrt && (wbFwdReg == srcRegA))
            op_a = wbFwdData;
    end

    // Same priority for the B register operand, which also feeds store data.
    always_comb begin
        reg2_fwd = reg2Data;
        if (memFwdWrt && (memFwdReg == srcRegB))
            reg2_fwd = memFwdData;
        else if (wbFwdWrt && (wbFwdReg == srcRegB))
            reg2_fwd = wbFwdData;
    end
`else
    assign op_a     = reg1Data;
    assign reg2_fwd = reg2Data;
`endif

    assign op_b = aluSrc ? immVal : reg2_fwd;

    alu16 u_alu (
        .a       (op_a),
        .b       (op_b),
        .alu_op  (aluOp),
        .set_op  (setOp),
        .result  (alu_result),
        .set_val (set_result),
        .illegal (alu_illegal)
    );

    // Branch condition and target; register jumps are relative to A.
    always_comb begin
        br_cond    = 1'b0;
        br_illegal = 1'b0;
        br_target  = nextPcIn + immVal;
        case (brOp)
            BR_NONE: br_cond = 1'b0;
            BR_BEQZ: br_cond = (op_a == '0);
            BR_BNEZ: br_cond = (op_a != '0);
            BR_BLTZ: br_cond = op_a[WIDTH-1];
            BR_BGEZ: br_cond = ~op_a[WIDTH-1];
            BR_JREG: begin
                br_cond   = 1'b1;
                br_target = op_a + immVal;
            end
            default: br_illegal = 1'b1;
        endcase
    end

    // Assemble the entry a real instruction would write into EX/MEM.
    always_comb begin
        d               = EXMEM_BUBBLE;
        d.alu_out       = alu_result;
        d.set_val       = set_result;
        d.reg1_data     = op_a;
        d.reg2_data     = reg2_fwd;
        d.next_pc       = nextPcIn;
        d.instr         = instr;
        d.mem_wrt       = memWrtIn;
        d.mem_en        = memEnIn;
        d.reg_wrt       = regWrtIn;
        d.err           = alu_illegal | br_illegal;
        d.halt          = haltIn | alu_illegal | br_illegal;
        d.valid         = 1'b1;
        d.reg_wrt_src   = regWrtSrcIn;
        d.write_reg     = writeRegIn;
        d.branch_taken  = br_cond;
        d.branch_target = br_target;
    end

    // EX/MEM register: stall holds; a taken branch squashes the next slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= EXMEM_BUBBLE;
        else if (!stall) begin
            if (q.branch_taken || !inValid)
                q <= EXMEM_BUBBLE;
            else
                q <= d;
        end
    end

    assign aluOut       = q.alu_out;
    assign setVal       = q.set_val;
    assign reg1DataOut  = q.reg1_data;
    assign reg2DataOut  = q.reg2_data;
    assign nextPc       = q.next_pc;
    assign instrOut     = q.instr;
    assign memWrt       = q.mem_wrt;
    assign memEn        = q.mem_en;
    assign regWrt       = q.reg_wrt;
    assign halt         = q.halt;
    assign valid        = q.valid;
    assign regWrtSrc    = q.reg_wrt_src;
    assign writeReg     = q.write_reg;
    assign branchTaken  = q.branch_taken;
    assign branchTarget = q.branch_target;
    assign err          = q.err;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [15:0] instr, nextPcIn, reg1Data, reg2Data, immVal;
    logic        aluSrc;
    logic [3:0]  aluOp;
    logic [1:0]  setOp;
    logic [2:0]  brOp;
    logic        memWrtIn, memEnIn, regWrtIn, haltIn;
    logic [2:0]  regWrtSrcIn, writeRegIn;
    logic        stall;
    logic [15:0] aluOut, setVal, reg1DataOut, reg2DataOut, nextPc, instrOut;
    logic        memWrt, memEn, regWrt, halt, valid;
    logic [2:0]  regWrtSrc, writeReg;
    logic        branchTaken;
    logic [15:0] branchTarget;
    logic        err;
`ifdef EXECUTE_STAGE_FWD_EN
    logic        memFwdWrt, wbFwdWrt;
    logic [2:0]  memFwdReg, wbFwdReg, srcRegA, srcRegB;
    logic [15:0] memFwdData, wbFwdData;
`endif

    int vectors = 0;
    int miscompares = 0;

    execute_stage dut (
        .clk(clk), .rst(rst), .inValid(inValid), .instr(instr), .nextPcIn(nextPcIn),
        .reg1Data(reg1Data), .reg2Data(reg2Data), .immVal(immVal), .aluSrc(aluSrc),
        .aluOp(aluOp), .setOp(setOp), .brOp(brOp), .memWrtIn(memWrtIn), .memEnIn(memEnIn),
        .regWrtIn(regWrtIn), .haltIn(haltIn), .regWrtSrcIn(regWrtSrcIn), .writeRegIn(writeRegIn),
        .stall(stall), .aluOut(aluOut), .setVal(setVal), .reg1DataOut(reg1DataOut),
        .reg2DataOut(reg2DataOut), .nextPc(nextPc), .instrOut(instrOut), .memWrt(memWrt),
        .memEn(memEn), .regWrt(regWrt), .halt(halt), .valid(valid), .regWrtSrc(regWrtSrc),
        .writeReg(writeReg), .branchTaken(branchTaken), .branchTarget(branchTarget), .err(err)
`ifdef EXECUTE_STAGE_FWD_EN
        , .memFwdWrt(memFwdWrt), .memFwdReg(memFwdReg), .memFwdData(memFwdData),
        .wbFwdWrt(wbFwdWrt), .wbFwdReg(wbFwdReg), .wbFwdData(wbFwdData),
        .srcRegA(srcRegA), .srcRegB(srcRegB)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inValid = 0; instr = 0; nextPcIn = 0; reg1Data = 0; reg2Data = 0; immVal = 0;
        aluSrc = 0; aluOp = 0; setOp = 0; brOp = 0; memWrtIn = 0; memEnIn = 0;
        regWrtIn = 0; haltIn = 0; regWrtSrcIn = 0; writeRegIn = 0;
`ifdef EXECUTE_STAGE_FWD_EN
        memFwdWrt = 0; memFwdReg = 0; memFwdData = 0; wbFwdWrt = 0; wbFwdReg = 0;
        wbFwdData = 0; srcRegA = 0; srcRegB = 0;
`endif
    endtask

    task automatic alu_vec(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                           input logic [1:0] sop);
        idle_inputs();
        inValid = 1; reg1Data = a; reg2Data = b; aluOp = op; setOp = sop; regWrtIn = 1;
    endtask

    initial begin
        idle_inputs();
        stall = 0;
        rst = 1;
        #12;
        check("reset_valid", valid, 0);
        check("reset_branch", branchTaken, 0);
        check("reset_err", err, 0);
        check("reset_halt", halt, 0);
        check("reset_alu", aluOut, 0);
        @(negedge clk);
        rst = 0;
        step();

        // ADD overflow, SCO carry clear
        alu_vec(16'h7FFF, 16'h0001, 4'd0, 2'd3); writeRegIn = 3'd5;
        step();
        check("add_out", aluOut, 16'h8000);
        check("add_sco", setVal, 16'h0000);
        check("add_valid", valid, 1);
        check("add_regwrt", regWrt, 1);
        check("add_wreg", {13'd0, writeReg}, 16'h0005);

        // ROL by immediate, SLT 8001 < 4 signed
        alu_vec(16'h8001, 16'h0000, 4'd4, 2'd1); aluSrc = 1; immVal = 16'h0004;
        step();
        check("rol_out", aluOut, 16'h0018);
        check("rol_slt", setVal, 16'h0001);

        // SUB is B-A, SLT -1 < 1
        alu_vec(16'hFFFF, 16'h0001, 4'd1, 2'd1);
        step();
        check("sub_out", aluOut, 16'h0002);
        check("slt_neg", setVal, 16'h0001);

        // ADD wrap, SCO carry set
        alu_vec(16'hFFFF, 16'h0001, 4'd0, 2'd3);
        step();
        check("add_wrap", aluOut, 16'h0000);
        check("sco_set", setVal, 16'h0001);

        alu_vec(16'hF0F0, 16'h0FF0, 4'd2, 2'd2);
        step();
        check("xor_out", aluOut, 16'hFF00);
        check("sle_out", setVal, 16'h0001);

        alu_vec(16'hF0F0, 16'h0FF0, 4'd3, 2'd0);
        step();
        check("andn_out", aluOut, 16'hF000);
        check("seq_ne", setVal, 16'h0000);

        alu_vec(16'h8000, 16'h000F, 4'd7, 2'd0);
        step();
        check("srl_out", aluOut, 16'h0001);

        alu_vec(16'h0001, 16'h0003, 4'd5, 2'd0);
        step();
        check("sll_out", aluOut, 16'h0008);

        alu_vec(16'h0001, 16'h0001, 4'd6, 2'd0);
        step();
        check("ror_out", aluOut, 16'h8000);
        check("seq_eq", setVal, 16'h0001);

        alu_vec(16'hABCD, 16'hABCD, 4'd8, 2'd2);
        step();
        check("passb_out", aluOut, 16'hABCD);
        check("sle_eq", setVal, 16'h0001);

        // BEQZ taken, next instruction squashed
        alu_vec(16'h0000, 16'h0000, 4'd0, 2'd0);
        brOp = 3'd1; nextPcIn = 16'h0010; immVal = 16'hFFF8; regWrtIn = 0;
        step();
        check("beqz_taken", branchTaken, 1);
        check("beqz_target", branchTarget, 16'h0008);
        check("beqz_valid", valid, 1);
        alu_vec(16'h0001, 16'h0002, 4'd0, 2'd0);
        step();
        check("squash_valid", valid, 0);
        check("squash_regwrt", regWrt, 0);
        check("squash_branch", branchTaken, 0);
        step();
        check("post_squash_valid", valid, 1);
        check("post_squash_out", aluOut, 16'h0003);

        // BNEZ taken then held through a 3-cycle stall
        alu_vec(16'h0005, 16'h0000, 4'd0, 2'd0);
        brOp = 3'd2; nextPcIn = 16'h0020; immVal = 16'h0010;
        step();
        check("bnez_taken", branchTaken, 1);
        check("bnez_target", branchTarget, 16'h0030);
        alu_vec(16'h1000, 16'h0001, 4'd0, 2'd0); memWrtIn = 1;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_taken", branchTaken, 1);
            check("stall_target", branchTarget, 16'h0030);
            check("stall_valid", valid, 1);
            check("stall_out", aluOut, 16'h0005);
        end
        stall = 0;
        step();
        check("stall_squash_valid", valid, 0);
        check("stall_squash_taken", branchTaken, 0);
        check("stall_squash_memwrt", memWrt, 0);
        step();
        check("after_stall_valid", valid, 1);
        check("after_stall_out", aluOut, 16'h1001);

        // Back-to-back taken branches: the second never redirects
        alu_vec(16'h8000, 16'h0000, 4'd0, 2'd0);
        brOp = 3'd3; nextPcIn = 16'h0040; immVal = 16'h0002;
        step();
        check("bltz_taken", branchTaken, 1);
        check("bltz_target", branchTarget, 16'h0042);
        alu_vec(16'h0001, 16'h0000, 4'd0, 2'd0);
        brOp = 3'd4; nextPcIn = 16'h0050; immVal = 16'h0004;
        step();
        check("b2b_taken", branchTaken, 0);
        check("b2b_valid", valid, 0);
        step();
        check("bgez_taken", branchTaken, 1);
        check("bgez_target", branchTarget, 16'h0054);

        // Register jump
        alu_vec(16'h1000, 16'h0000, 4'd0, 2'd0);
        brOp = 3'd5; immVal = 16'h0234;
        step();
        check("jreg_bubble_after_bgez", valid, 0);
        step();
        check("jreg_taken", branchTaken, 1);
        check("jreg_target", branchTarget, 16'h1234);
        idle_inputs();
        step();

        // Illegal opcodes force err and halt
        alu_vec(16'h0001, 16'h0001, 4'hC, 2'd0);
        step();
        check("ill_alu_err", err, 1);
        check("ill_alu_halt", halt, 1);
        check("ill_alu_valid", valid, 1);
        alu_vec(16'h0000, 16'h0001, 4'd0, 2'd0); brOp = 3'd6;
        step();
        check("ill_br_err", err, 1);
        check("ill_br_halt", halt, 1);
        check("ill_br_taken", branchTaken, 0);
        alu_vec(16'h0000, 16'h0001, 4'd0, 2'd0);
        step();
        check("legal_err", err, 0);
        check("legal_halt", halt, 0);

        // inValid low gives a bubble
        alu_vec(16'h0002, 16'h0002, 4'd0, 2'd0); inValid = 0;
        step();
        check("invalid_valid", valid, 0);
        check("invalid_regwrt", regWrt, 0);

        // Async reset mid-stall
        alu_vec(16'h0002, 16'h0002, 4'd0, 2'd0); memEnIn = 1;
        step();
        check("pre_rst_valid", valid, 1);
        stall = 1;
        step();
        #2;
        rst = 1;
        #1;
        check("async_rst_valid", valid, 0);
        check("async_rst_alu", aluOut, 0);
        check("async_rst_memen", memEn, 0);
        check("async_rst_regwrt", regWrt, 0);
        @(negedge clk);
        rst = 0;
        step();
        check("rst_stall_hold", valid, 0);
        stall = 0;
        step();
        check("post_rst_valid", valid, 1);
        check("post_rst_out", aluOut, 16'h0004);

`ifdef EXECUTE_STAGE_FWD_EN
        alu_vec(16'h0000, 16'h0000, 4'd0, 2'd0);
        memFwdWrt = 1; memFwdReg = 3; memFwdData = 16'h1111;
        wbFwdWrt = 1; wbFwdReg = 3; wbFwdData = 16'h2222;
        srcRegA = 3; srcRegB = 4;
        step();
        check("fwd_mem_prio", aluOut, 16'h1111);
        srcRegB = 3; memFwdReg = 2; srcRegA = 2; reg2Data = 16'h5555;
        wbFwdReg = 3;
        step();
        check("fwd_wb_b", reg2DataOut, 16'h2222);
        check("fwd_sum", aluOut, 16'h3333);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage 16-bit pipeline, between decode and `memoryStage`. It performs ALU, shift/rotate and set-compare operations, and resolves conditional branches and register jumps. Results go into the EX/MEM pipeline register, which also carries every control field `memoryStage` consumes. The register supports stall, bubble insertion and single-slot squash after a taken branch.

## Interface
Parameters:
- `WIDTH`, 16, datapath width; only 16 is supported.

Ports:
- `clk  in  1  rising-edge clock`
- `rst  in  1  asynchronous, active-high reset`
- `inValid  in  1  decode presents a real instruction`
- `instr, nextPcIn, reg1Data, reg2Data, immVal  in  16 each  instruction, PC+2, Rs, Rt, sign-extended immediate`
- `aluSrc  in  1  0: B operand = reg2Data; 1: B operand = immVal`
- `aluOp  in  4  ALU operation code`
- `setOp  in  2  set-compare code`
- `brOp  in  3  branch/jump code`
- `memWrtIn, memEnIn, regWrtIn, haltIn  in  1 each  control fields passed through`
- `regWrtSrcIn, writeRegIn  in  3 each  control fields passed through`
- `stall  in  1  memory not ready: hold the EX/MEM register`
- `aluOut, setVal, reg1DataOut, reg2DataOut, nextPc, instrOut  out  16 each  registered`
- `memWrt, memEn, regWrt, halt, valid  out  1 each  registered`
- `regWrtSrc, writeReg  out  3 each  registered`
- `branchTaken  out  1  registered redirect request`
- `branchTarget  out  16  registered redirect address`
- `err  out  1  registered illegal-opcode flag`

## Operation
- Operand A is `reg1Data`. Operand B is selected by `aluSrc`.
- `aluOp` codes:
  - 0 ADD: A+B
  - 1 SUB: B−A
  - 2 XOR
  - 3 ANDN: A&~B
  - 4 ROL, 5 SLL, 6 ROR, 7 SRL: shift amount is B[3:0]
  - 8 PASSB
  - 9–15 illegal: err=1
- All arithmetic is modulo 2^16.
- `setVal` is 16'h0001 or 16'h0000. `setOp` codes:
  - 0 SEQ: A==B
  - 1 SLT: signed A<B
  - 2 SLE: signed A≤B
  - 3 SCO: carry out of the 17-bit sum A+B
- `brOp` codes:
  - 0 none
  - 1 BEQZ: A==0
  - 2 BNEZ: A!=0
  - 3 BLTZ: A[15]=1
  - 4 BGEZ: A[15]=0
  - 5 JUMP-REG: always taken, target = A+immVal
  - 6–7 illegal: err=1
  - For codes 1–4 the target is nextPcIn+immVal.
- Capture rule on each rising edge:
  - `stall`=1: every register holds.
  - Else if `branchTaken`=1: capture a bubble, i.e. valid=0 and memWrt, memEn, regWrt, halt, branchTaken, err all 0. This squashes exactly the one younger instruction.
  - Else if `inValid`=0: capture a bubble.
  - Else: capture the new results and pass-through fields, with `valid`=1.
- A bubble's data fields are don't-care; the bench must not check them.
- `err` forces `halt`=1 in the same captured entry.

## Timing
- Latency is one cycle from inputs to registered outputs.
- No combinational input-to-output path exists.
- Reset values: all outputs are 0, including `valid`, `branchTaken`, `err` and `halt`.
- Reset applies asynchronously. If reset asserts mid-stall, the register still clears, and the first post-reset capture obeys the normal rules.
- `branchTaken` is high for exactly one non-stalled cycle per taken branch.
- Under `stall`, `branchTaken` and `branchTarget` hold. The squash applies at the first non-stalled edge.
- Simultaneous `stall` and taken branch: stall has priority.
- Back-to-back taken branches: the second is squashed and never redirects.

## Configuration
- Macro `EXECUTE_STAGE_FWD_EN`.
- When defined, these inputs are added:
  - `memFwdWrt` (1), `memFwdReg` (3), `memFwdData` (16): EX/MEM result.
  - `wbFwdWrt` (1), `wbFwdReg` (3), `wbFwdData` (16): MEM/WB result.
  - `srcRegA`, `srcRegB` (3 each): source register numbers.
- Forwarding replaces `reg1Data`/`reg2Data` when the write-enable is set and the register number matches.
- The MEM forward takes priority over the WB forward. `reg2DataOut` carries the forwarded value.
- When undefined, these ports do not exist and operands come straight from the inputs.

## Structure
- Shared package `pipe_pkg`:
  - `aluOp`, `setOp` and `brOp` encodings
  - `WIDTH`
  - the bubble constant
- One sub-module, `alu16`: a combinational ALU plus set-compare producing `aluOut`, `setVal` and an illegal flag.
- Branch resolution, forwarding muxes and the EX/MEM register stay in `execute_stage`.

## Test plan
- ADD: A=16'h7FFF, B=16'h0001, aluOp=0, setOp=3 -> next cycle aluOut=16'h8000, setVal=0, valid=1.
- ROL: A=16'h8001, B=16'h0004 -> aluOut=16'h0018. SLT: A=16'hFFFF, B=16'h0001 -> setVal=1.
- BEQZ: A=0, nextPcIn=16'h0010, immVal=16'hFFF8 -> branchTaken=1, branchTarget=16'h0008. The following instruction is squashed (valid=0, regWrt=0).
- Taken branch with `stall`=1 for 3 cycles -> outputs frozen; the squash lands on the first cycle after stall drops; branchTaken is high for one non-stalled cycle only.
- aluOp=4'hC -> err=1 and halt=1 next cycle. Asserting rst mid-stall -> all outputs 0 immediately, without waiting for a clock edge.
- With `EXECUTE_STAGE_FWD_EN`: memFwdReg=wbFwdReg=srcRegA=3, memFwdData=16'h1111, wbFwdData=16'h2222, ADD with B=0 -> aluOut=16'h1111.
